// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, receiver state encoding and frame-length
//               helper for the UART program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Receiver FSM states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Total bits in one frame: start + data + optional parity + stop bits
  function automatic int frame_bits(input int data_w, input int parity,
                                    input int stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : Configurable UART receiver: 2-FF synchroniser, bit timer,
//               LSB-first shifter and frame FSM. Emits one-cycle valid,
//               frame-error and parity-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 24,
  parameter int DATA_W       = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] word_o,
  output logic              valid_o,
  output logic              fe_o,
  output logic              pe_o,
  output logic              busy_o
);

  localparam int FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
  localparam int BITS_W     = $clog2(FRAME_BITS);
  localparam int CNT_W      = $clog2(CLKS_PER_BIT);

  // Start bit is sampled half a bit in; every later bit one full bit later
  localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BITS_W-1:0] DATA_LAST   = BITS_W'(DATA_W - 1);
  localparam logic [BITS_W-1:0] STOP_LAST   = BITS_W'(STOP_BITS - 1);
  localparam logic              PAR_INV     = (PARITY == PAR_ODD);

  logic              sync_q;
  logic              rxs_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_err_q, par_err_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              pe_q, pe_d;
  logic              tick;

  assign tick    = (cnt_q == '0);
  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign fe_o    = fe_q;
  assign pe_o    = pe_q;
  assign busy_o  = (state_q != S_IDLE);

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rx_i;
      rxs_q  <= sync_q;
    end
  end

  // Frame FSM, bit timer and shifter: next-state and registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The line only returns here while high, so a low level is a fall
        if (!rxs_q) begin
          state_d   = S_START;
          cnt_d     = HALF_RELOAD;
          par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_RELOAD;
            bits_d  = DATA_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = {rxs_q, shreg_q[DATA_W-1:1]};
          cnt_d   = FULL_RELOAD;
          if (bits_q == '0) begin
            if (PARITY != PAR_NONE) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
              bits_d  = STOP_LAST;
            end
          end else begin
            bits_d = bits_q - BITS_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          par_err_d = rxs_q ^ (^shreg_q) ^ PAR_INV;
          cnt_d     = FULL_RELOAD;
          state_d   = S_STOP;
          bits_d    = STOP_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = FULL_RELOAD;
          if (!rxs_q) begin
            fe_d    = 1'b1;
            state_d = S_WAIT_IDLE;
          end else if (bits_q == '0) begin
            state_d = S_IDLE;
            if (par_err_q) begin
              pe_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              word_d  = shreg_q;
            end
          end else begin
            bits_d = bits_q - BITS_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        // Absorb a break: wait for the line to go high again
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : UART receiver plus sequential program-memory loader. While
//               Load is high, good words are written to consecutive
//               addresses until DEPTH words are loaded. Error flags sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 24,
  parameter int DATA_W       = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RX,
  input  logic              Load,
  output logic [DATA_W-1:0] Rx_data,
  output logic              Rx_valid,
  output logic              Wr_en,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [DATA_W-1:0] Wr_data,
  output logic              Done,
  output logic              FE,
  output logic              PE,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] core_word;
  logic              core_valid;
  logic              core_fe;
  logic              core_pe;

  logic              load_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              fe_q, fe_d;
  logic              pe_q, pe_d;
  logic              load_rise;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_core (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .rx_i    (RX),
    .word_o  (core_word),
    .valid_o (core_valid),
    .fe_o    (core_fe),
    .pe_o    (core_pe),
    .busy_o  (Busy)
  );

  // Load edge clear, write gating at commit, pointer advance and sticky flags
  always_comb begin
    load_rise = Load & ~load_q;
    // A restart coinciding with a commit sends that word to address 0
    wr_addr   = load_rise ? '0 : ptr_q;
    wr_fire   = core_valid & Load & (load_rise | ~done_q);
    ptr_d     = wr_addr;
    done_d    = done_q & ~load_rise;
    fe_d      = (fe_q & ~load_rise) | core_fe;
    pe_d      = (pe_q & ~load_rise) | core_pe;
    if (wr_fire) begin
      if (wr_addr == LAST_ADDR) begin
        done_d = 1'b1;
      end else begin
        ptr_d = wr_addr + ADDR_W'(1);
      end
    end
  end

  // Loader registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_q <= 1'b0;
      ptr_q  <= '0;
      done_q <= 1'b0;
      fe_q   <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      load_q <= Load;
      ptr_q  <= ptr_d;
      done_q <= done_d;
      fe_q   <= fe_d;
      pe_q   <= pe_d;
    end
  end

  assign Rx_data  = core_word;
  assign Rx_valid = core_valid;
  assign Wr_en    = wr_fire;
  assign Wr_addr  = wr_addr;
  assign Wr_data  = wr_fire ? core_word : '0;
  assign Done     = done_q;
  assign FE       = fe_q;
  assign PE       = pe_q;

endmodule
`default_nettype wire
